// File: rtl/instr_fetch.sv
`default_nettype none
// instr_fetch: IF-stage fetch sequencer with credit-limited requests, in-flight PC tracking,
// an output FIFO toward decode and stale-response dropping after redirects.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   input  logic        id_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] r_count;
   logic [31:0]   r_pcq [DEPTH];
   logic [AW-1:0] r_pcq_wr;
   logic [AW-1:0] r_pcq_rd;
   logic [31:0]   r_fifo_pc    [DEPTH];
   logic [31:0]   r_fifo_instr [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;

   logic [CW:0]   w_credit_sum;
   logic          w_req_fire;
   logic          w_pop;
   logic          w_dropping;
   logic          w_push;

   // Credit counts both outstanding requests and buffered entries, so a
   // returning response always finds a free FIFO slot.
   assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, r_count};
   assign imem_req_valid = rst & (w_credit_sum < (CW+1)'(DEPTH));
   assign imem_req_addr  = r_fetch_pc;

   assign w_req_fire = imem_req_valid & imem_req_ready;
   assign w_pop      = id_valid & id_ready;
   assign w_dropping = (r_drop != '0);
   assign w_push     = imem_rsp_valid & ~w_dropping & ~redirect_valid;

   assign id_valid = (r_count != '0);
   assign id_pc    = r_fifo_pc[r_rd];
   assign id_instr = r_fifo_instr[r_rd];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_pcq_wr   <= '0;
         r_pcq_rd   <= '0;
         for (int i = 0; i < DEPTH; i++) r_pcq[i] <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
         if (w_req_fire) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
            r_pcq_wr        <= r_pcq_wr + AW'(1);
         end
         if (imem_rsp_valid) r_pcq_rd <= r_pcq_rd + AW'(1);

         if (redirect_valid)
            r_fetch_pc <= redirect_pc;
         else if (w_req_fire)
            r_fetch_pc <= r_fetch_pc + 32'd4;

         // Everything still outstanding after this edge belongs to the old path.
         if (redirect_valid)
            r_drop <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
         else if (imem_rsp_valid && w_dropping)
            r_drop <= r_drop - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_fifo_pc[i]    <= '0;
            r_fifo_instr[i] <= '0;
         end
      end else if (redirect_valid) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo_pc[r_wr]    <= r_pcq[r_pcq_rd];
            r_fifo_instr[r_wr] <= imem_rsp_data;
            r_wr               <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the pipelined core's IF stage. Owns the fetch PC and issues word requests to instruction memory over a valid/ready channel. Tracks in-flight requests and buffers returned instructions with their PCs in a small FIFO. Presents them to the IF/ID boundary with valid/ready, and discards stale responses after a control-flow redirect from EX.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- DEPTH, 4, FIFO entries and maximum requests in flight plus buffered; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; state clears immediately while low.
- redirect_valid  in  1  EX-stage branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch target; word-aligned.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address (current fetch PC).
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response data valid; responses are in order, never back-pressured, earliest one cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  FIFO head valid toward decode.
- id_pc  out  32  PC of head instruction.
- id_instr  out  32  head instruction.
- id_ready  in  1  decode consumes head this cycle.

## Operation
- State:
  - fetch_pc (32).
  - inflight counter: accepted requests awaiting response.
  - drop counter: responses to be discarded.
  - PC queue of in-flight addresses, DEPTH entries.
  - Output FIFO of {pc, instr}, DEPTH entries, with count.
- Counters are $clog2(DEPTH)+1 bits wide.
- Credit rule: imem_req_valid = (inflight + count) < DEPTH, computed from registered state only. It is not gated by redirect_valid or id_ready.
- imem_req_addr = fetch_pc.
- Request handshake (valid & ready):
  - Push fetch_pc into the PC queue.
  - inflight++.
  - fetch_pc += 4, modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- Response handling:
  - Pop the PC queue and decrement inflight.
  - If drop > 0: discard the response and decrement drop.
  - Otherwise: push {popped pc, imem_rsp_data} into the FIFO.
- A response that would be pushed while count == DEPTH cannot occur by the credit rule; the bench asserts this never happens.
- Decode handshake (id_valid & id_ready): pop the FIFO head.
- id_valid = (count != 0). id_pc and id_instr show the head entry and are stable while id_valid & !id_ready.
- Redirect (redirect_valid = 1) takes priority over all other updates to fetch_pc and the FIFO:
  - fetch_pc <= redirect_pc.
  - FIFO count <= 0, except that a same-cycle decode pop still counts as a transfer.
  - drop <= all requests outstanding after this cycle. That is inflight, plus 1 if a request handshakes this cycle, minus 1 if a response arrives this cycle.
  - A response arriving in the redirect cycle is discarded, never pushed.
  - A request accepted in the redirect cycle carries the old address and is dropped on return.
- imem_req_addr may change while imem_req_valid is held high without ready, only in a redirect cycle. Instruction memory tolerates this.

## Timing
- Reset (rst low), asynchronous:
  - fetch_pc = RESET_PC; inflight, drop and count = 0.
  - imem_req_valid = 0 while rst is low.
  - imem_req_addr = RESET_PC.
  - id_valid = 0; id_pc = 0; id_instr = 0. Storage is cleared to 0.
- Reset release: imem_req_valid goes high in the first cycle with rst high, because credit is available.
- Latency: response at edge N gives id_valid = 1 after edge N; decode sees it in cycle N+1.
- Throughput: with 1–2 cycle memory latency, DEPTH = 4 and id_ready held high, the block sustains one instruction per cycle.
- Redirect latency:
  - First request to redirect_pc is issued in the cycle after the redirect edge.
  - No pre-redirect instruction appears on id_* after that edge.
- Reset mid-operation: everything is lost. Instruction memory shares rst, so no stale responses arrive after release.

## Test plan
- Sequential fetch:
  - Setup: RESET_PC = 0x100, 1-cycle memory returning addr ^ 0xA5A5_0000, id_ready = 1.
  - Required: requests 0x100, 0x104, 0x108, …; id stream in the same order with matching data, one per cycle in steady state.
- Back-pressure:
  - Stimulus: id_ready = 0 from reset.
  - Required: exactly 4 requests accepted, then imem_req_valid = 0. id_pc holds 0x100 and id_instr holds 0xA5A5_0100.
  - On releasing id_ready: 0x100 through 0x10C delivered once each, then fetching resumes at 0x110.
- Redirect with 2 in flight:
  - Stimulus: 3-cycle memory; redirect_pc = 0x2000.
  - Required: both old responses discarded; next id_pc = 0x2000; no id_valid for old PCs after the redirect edge.
- Redirect coinciding with a request handshake and a response in the same cycle:
  - Required: drop = inflight + 1 − 1; both the concurrently accepted request and the arriving response are discarded.
  - Required: first delivered PC = redirect_pc.
- Wrap:
  - Setup: RESET_PC = 0xFFFF_FFF8.
  - Required: id_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Asynchronous reset mid-stream:
  - Stimulus: rst low between clock edges, with FIFO non-empty.
  - Required: id_valid and imem_req_valid drop immediately without waiting for a clock edge.
  - Required: after release, fetch restarts at RESET_PC.
